// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioning front end.
package btn_pkg;

    // Board button channel indices.
    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_D = 4;

    // 10 ms debounce and 1.0 s long press at 100 MHz.
    localparam int unsigned DB_CYCLES_DEFAULT   = 1_000_000;
    localparam int unsigned LONG_CYCLES_DEFAULT = 100_000_000;

    // Per-channel state: released, pressed (timing hold), long press reported.
    typedef enum logic [1:0] {
        REL,
        PRS,
        LNG
    } btn_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce counter, hold timer and
// press/release/long event generation. All outputs come straight from flops.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEFAULT,
    parameter int unsigned CNT_W       = $clog2(LONG_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic held_o
);

    localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] dbc_q, dbc_d;
    logic [CNT_W-1:0] hc_q, hc_d;
    btn_state_e       state_q, state_d;
    logic             rise, fall;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             held_q, held_d;

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    // Debounce: count consecutive cycles s2 disagrees with the stable level.
    always_comb begin
        dbc_d = dbc_q;
        rise  = 1'b0;
        fall  = 1'b0;
        if (s2_q == level_q) begin
            dbc_d = '0;
        end else if (dbc_q == DbLast) begin
            dbc_d = '0;
            rise  = s2_q;
            fall  = ~s2_q;
        end else begin
            dbc_d = dbc_q + CNT_W'(1);
        end
    end

    // State, counter and registered output updates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= REL;
            dbc_q     <= '0;
            hc_q      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dbc_q     <= dbc_d;
            hc_q      <= hc_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= held_d;
        end
    end

    // Next state and hold counter; a debounced fall beats the long threshold.
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        unique case (state_q)
            REL: begin
                if (rise) begin
                    state_d = PRS;
                    hc_d    = '0;
                end
            end
            PRS: begin
                if (fall) begin
                    state_d = REL;
                    hc_d    = '0;
                end else if (hc_q == LongLast) begin
                    state_d = LNG;  // hc parks at the threshold
                end else begin
                    hc_d = hc_q + CNT_W'(1);
                end
            end
            LNG: begin
                if (fall) begin
                    state_d = REL;
                    hc_d    = '0;
                end
            end
            default: begin
                state_d = REL;
                hc_d    = '0;
            end
        endcase
    end

    // Output next-state decoded from the transition being taken.
    always_comb begin
        level_d   = (state_d != REL);
        press_d   = (state_q == REL) && (state_d == PRS);
        release_d = (state_q != REL) && (state_d == REL);
        long_d    = (state_q == PRS) && (state_d == LNG);
        held_d    = (state_d == LNG);
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign held_o    = held_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw pushbuttons into clean levels and single-cycle
// press/release/long-press events for the subtask state machine.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN       = 5,
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_held
);

    localparam int unsigned CNT_W = $clog2(LONG_CYCLES + 1);

    // One independent conditioner per button.
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES  (DB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk_i    (clk),
            .rst_i    (rst),
            .raw_i    (btn_raw[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i]),
            .long_o   (btn_long[i]),
            .held_o   (btn_held[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised + directed bench with a look-back reference model and scoreboard.
module tb_button_conditioner;

    localparam int N    = 5;
    localparam int DB   = 4;
    localparam int LONG = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_long, btn_held;

    button_conditioner #(
        .N_BTN      (N),
        .DB_CYCLES  (DB),
        .LONG_CYCLES(LONG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long),
        .btn_held   (btn_held)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected {level, press, release, long, held} after each clock edge.
    logic [5*N-1:0] exp_q[$];

    // Reference model state.
    logic [N-1:0] raw_at[int];
    int           cyc      = 0;
    int           last_rst = -1000;
    bit           stable[N];
    bit           long_done[N];
    int           last_evt[N];
    int           press_cyc[N];
    logic [N-1:0] m_level, m_press, m_rel, m_long, m_held;
    bit           flip;

    // Value seen by the debouncer at edge k: raw sampled two edges earlier,
    // or 0 if a reset hit the synchroniser in between.
    function automatic bit vsamp(input int ch, input int k);
        if (k - 2 <= last_rst || !raw_at.exists(k - 2)) return 1'b0;
        return raw_at[k-2][ch];
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        raw_at[cyc] = btn_raw;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        if (rst) begin
            last_rst = cyc;
            for (int ch = 0; ch < N; ch++) begin
                stable[ch]    = 1'b0;
                long_done[ch] = 1'b0;
                last_evt[ch]  = cyc;
            end
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                // Level flips once the last DB samples since the previous
                // flip/reset all disagree with it.
                flip = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    if (cyc - j <= last_evt[ch] || vsamp(ch, cyc - j) == stable[ch])
                        flip = 1'b0;
                end
                if (flip) begin
                    stable[ch]    = ~stable[ch];
                    last_evt[ch]  = cyc;
                    long_done[ch] = 1'b0;
                    if (stable[ch]) begin
                        m_press[ch]   = 1'b1;
                        press_cyc[ch] = cyc;
                    end else begin
                        m_rel[ch] = 1'b1;
                    end
                end else if (stable[ch] && !long_done[ch] && cyc - press_cyc[ch] == LONG) begin
                    m_long[ch]    = 1'b1;
                    long_done[ch] = 1'b1;
                end
            end
        end
        for (int ch = 0; ch < N; ch++) begin
            m_level[ch] = stable[ch];
            m_held[ch]  = long_done[ch];
        end
        exp_q.push_back({m_level, m_press, m_rel, m_long, m_held});
    end

    // Monitor: every cycle the DUT presents a full output vector.
    logic [5*N-1:0] got, want;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {btn_level, btn_press, btn_release, btn_long, btn_held};
            checks = checks + 1;
            if (got !== want) begin
                failures = failures + 1;
                $display("FAIL outputs cyc=%0d {lvl,prs,rel,lng,hld} got=%h exp=%h",
                         cyc, got, want);
            end
        end
    end

    task automatic step(input logic [N-1:0] r, input logic rs, input int n);
        for (int i = 0; i < n; i++) begin
            btn_raw = r;
            rst     = rs;
            @(posedge clk);
            #1;
        end
    endtask

    int           hold_left[N];
    logic [N-1:0] rnd_raw;
    logic         rnd_rst;

    initial begin
        btn_raw = '0;
        rst     = 1'b1;
        step(5'b00000, 1'b1, 3);
        step(5'b00000, 1'b0, 3);
        // Clean press on U.
        step(5'b00010, 1'b0, 12);
        step(5'b00000, 1'b0, 10);
        // Bounce on C, then hold.
        step(5'b00001, 1'b0, 1);
        step(5'b00000, 1'b0, 1);
        step(5'b00001, 1'b0, 1);
        step(5'b00000, 1'b0, 1);
        step(5'b00001, 1'b0, 15);
        step(5'b00000, 1'b0, 10);
        // Long press on D.
        step(5'b10000, 1'b0, 40);
        step(5'b00000, 1'b0, 10);
        // Chord: C held, U short.
        step(5'b00001, 1'b0, 5);
        step(5'b00011, 1'b0, 10);
        step(5'b00001, 1'b0, 15);
        step(5'b00000, 1'b0, 10);
        // Reset during a long hold on L, button kept down through reset.
        step(5'b00100, 1'b0, 30);
        step(5'b00100, 1'b1, 2);
        step(5'b00100, 1'b0, 12);
        step(5'b00000, 1'b0, 10);
        // Release timed so the debounced fall meets the long threshold.
        step(5'b00100, 1'b0, LONG);
        step(5'b00000, 1'b0, 12);
        // Random phase: per-channel random hold lengths, occasional reset.
        rnd_raw = '0;
        for (int ch = 0; ch < N; ch++) hold_left[ch] = $urandom_range(1, 45);
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                hold_left[ch] = hold_left[ch] - 1;
                if (hold_left[ch] <= 0) begin
                    rnd_raw[ch]   = ~rnd_raw[ch];
                    hold_left[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                                : $urandom_range(4, 45);
                end
            end
            rnd_rst = ($urandom_range(0, 399) == 0);
            step(rnd_raw, rnd_rst, 1);
        end
        step(5'b00000, 1'b0, 10);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() > 1) begin
            failures = failures + 1;
            $display("FAIL scoreboard_drain pending=%0d required<=1", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage between the five raw board pushbuttons and the top-level subtask state machine.
- Each button is synchronised, debounced with a fixed-length stability counter, and exposed to the FSM in three forms:
  - a clean level;
  - single-cycle press and release pulses;
  - a long-press pulse and level.
- Replaces ad-hoc two-flop edge detection, so FSM transitions such as "btnU pressed while btnC held" fire exactly once per physical press.

Parameters:
- N_BTN, 5, number of independent button channels.
- DB_CYCLES, 1_000_000, consecutive clk cycles the synchronised input must differ from the debounced level before the level flips (10 ms at 100 MHz). Must be >= 1.
- LONG_CYCLES, 100_000_000, clk cycles the debounced level must stay high before the long-press event fires (1.0 s). Must be > DB_CYCLES.
- CNT_W, $clog2(LONG_CYCLES+1), width of the per-channel counters (derived; do not override).

Ports:
- clk  input  1  100 MHz system clock.
- rst  input  1  synchronous active-high reset.
- btn_raw  input  N_BTN  asynchronous raw button inputs (1 = pressed).
- btn_level  output  N_BTN  debounced level per button.
- btn_press  output  N_BTN  one-cycle pulse on a debounced 0->1 transition.
- btn_release  output  N_BTN  one-cycle pulse on a debounced 1->0 transition.
- btn_long  output  N_BTN  one-cycle pulse when a press reaches LONG_CYCLES.
- btn_held  output  N_BTN  high from the btn_long pulse until the debounced release.

Behaviour:
- Reset (rst=1 at a clk edge):
  - sync flops, stable level, both counters and all outputs go to 0;
  - every channel enters state REL.
- Synchroniser: two flops per channel; s2 is the synchronised input. Raw-to-s2 latency is 2 cycles.
- Per-channel FSM states:
  - REL: stable=0.
  - PRS: stable=1, hold counter running.
  - LNG: stable=1, long press already reported.
- Debounce counter (dbc):
  - If s2 == stable, dbc <= 0.
  - Else if dbc == DB_CYCLES-1, the stable level flips, dbc <= 0, and the matching pulse is set.
  - Else dbc <= dbc+1.
  - A single-cycle glitch back to the stable value restarts the count from 0.
- Latency: for a clean raw step, btn_level and the btn_press/btn_release pulse become visible DB_CYCLES+2 cycles after the first edge sampling the new raw value. Pulse and level change appear in the same cycle.
- Transitions:
  - REL -> PRS on a debounced rise: btn_press=1 for 1 cycle, hold counter (hc) <= 0.
  - PRS: hc increments each cycle. When hc == LONG_CYCLES-1, go PRS -> LNG with btn_long=1 for 1 cycle and btn_held <= 1. hc saturates, with no wrap.
  - PRS or LNG -> REL on a debounced fall: btn_release=1 for 1 cycle, btn_held <= 0 in the same cycle, hc <= 0.
  - A release in PRS never produces btn_long.
- Boundary cases:
  - Long threshold and debounced fall in the same cycle: the fall wins. btn_release fires and btn_long does not.
  - At most one of btn_press, btn_release, btn_long is high per channel per cycle.
  - Channels are fully independent. Simultaneous presses on several buttons produce pulses in the same cycle.
- Reset mid-operation: any pending count or held state is discarded. A button physically held through reset deassertion is reported as a fresh press DB_CYCLES+2 cycles after rst falls.
- DB_CYCLES=1: the level follows s2 one cycle after a change, still with a pulse.
- All outputs are registered; there is no combinational path from btn_raw to any output.

Decomposition:
- Shared package btn_pkg holds:
  - button index constants BTN_C=0, BTN_U=1, BTN_L=2, BTN_R=3, BTN_D=4;
  - default DB_CYCLES and LONG_CYCLES;
  - the channel state enum {REL, PRS, LNG}.
- One sub-module, btn_debounce_ch, implements a single channel (sync, dbc, hc, FSM, pulses).
- button_conditioner instantiates btn_debounce_ch N_BTN times via a generate loop and concatenates the outputs.

Test Plan (DB_CYCLES=4, LONG_CYCLES=20, N_BTN=5):
- Clean press: raw[1] 0->1 and held.
  - btn_level[1] and btn_press[1] rise 6 cycles later.
  - btn_press[1] is high exactly 1 cycle; all other channels stay 0.
- Bounce: raw[0] toggles 1,0,1,0 on alternate cycles, then holds 1.
  - No output changes during the toggling.
  - btn_press[0] fires once, 6 cycles after the final 0->1.
- Long press: hold raw[4] at 1 for 40 cycles, then release.
  - btn_long[4] pulses 20 cycles after btn_press[4]; btn_held[4]=1.
  - On the debounced fall, btn_release[4] fires and btn_held[4] returns to 0 in the same cycle.
- Chord and short release: raw[0] held; raw[1] pulsed high for 10 cycles.
  - btn_press[1] fires while btn_level[0]=1.
  - btn_release[1] fires later, with no btn_long[1].
- Reset mid-press: assert rst for 2 cycles while raw[2]=1 and btn_held[2]=1.
  - All outputs are 0 during and immediately after reset.
  - btn_press[2] fires again 6 cycles after rst deasserts.
- Threshold collision: time the release so that the debounced fall lands on hc == 19.
  - btn_release[2]=1, btn_long[2]=0, btn_held[2] stays 0.
